// File: rtl/isa_bus_engine.sv
// ISA bus master: host I/O read/write cycles and device-to-host DMA cycles
// sharing one SETUP/CMD/HOLD/DONE strobe sequencer, plus IRQ/DRQ synchronisers.
module isa_bus_engine #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int NUM_DMA    = 4,
    parameter int NUM_IRQ    = 4,
    parameter int SETUP_CYC  = 2,
    parameter int CMD_CYC    = 4,
    parameter int HOLD_CYC   = 1,
    parameter int CLK_DIV    = 4,
    parameter int RESET_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [DATA_W-1:0]  avs_writedata,
    output logic [DATA_W-1:0]  avs_readdata,
    output logic               avs_waitrequest,
    output logic [ADDR_W-1:0]  isa_address,
    output logic               isa_aen,
    output logic [DATA_W-1:0]  isa_data_out,
    input  logic [DATA_W-1:0]  isa_data_in,
    output logic               isa_data_oe,
    output logic               isa_ior_n,
    output logic               isa_iow_n,
    output logic               isa_clk,
    output logic               isa_reset,
    input  logic [NUM_DMA-1:0] isa_drq,
    output logic [NUM_DMA-1:0] isa_dack_n,
    input  logic [NUM_IRQ-1:0] isa_irq,
    output logic [NUM_IRQ-1:0] irq_out,
    output logic               dma_valid,
    input  logic               dma_ready,
    output logic [DATA_W-1:0]  dma_data,
    output logic [2:0]         dma_channel,
    output logic [3:0]         state_out
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RSTHOLD = 4'd1,
        SETUP   = 4'd2,
        CMD     = 4'd3,
        HOLD    = 4'd4,
        DONE    = 4'd5
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] RH_LAST    = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, div_cnt;
    logic [NUM_DMA-1:0] drq_s1, drq_s2;
    logic [NUM_IRQ-1:0] irq_s1, irq_s2;
    logic               is_dma, is_read, isa_clk_q;
    logic [2:0]         ch_q, grant_ch;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q, cap_q;
    logic               grant_dma, grant_host, busy;

    always_comb begin
        state_nxt  = state;
        grant_dma  = 1'b0;
        grant_host = 1'b0;
        grant_ch   = '0;
        // Descending scan so the lowest requesting channel is the one left standing
        for (int i = NUM_DMA - 1; i >= 0; i--)
            if (drq_s2[i]) grant_ch = 3'(i);
        case (state)
            RSTHOLD: if (cnt == RH_LAST) state_nxt = IDLE;
            IDLE: begin
                if (|drq_s2) begin
                    grant_dma = 1'b1;
                    state_nxt = SETUP;
                end else if (avs_read || avs_write) begin
                    grant_host = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP:   if (cnt == SETUP_LAST) state_nxt = CMD;
            CMD:     if (cnt == CMD_LAST)   state_nxt = HOLD;
            HOLD:    if (cnt == HOLD_LAST)  state_nxt = DONE;
            DONE:    if (!is_dma || dma_ready) state_nxt = IDLE;
            default: state_nxt = RSTHOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RSTHOLD;
            cnt       <= '0;
            drq_s1    <= '0;
            drq_s2    <= '0;
            irq_s1    <= '0;
            irq_s2    <= '0;
            is_dma    <= 1'b0;
            is_read   <= 1'b0;
            ch_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cap_q     <= '0;
            div_cnt   <= '0;
            isa_clk_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= (state_nxt != state) ? '0 : cnt + 1'b1;
            drq_s1 <= isa_drq;
            drq_s2 <= drq_s1;
            irq_s1 <= isa_irq;
            irq_s2 <= irq_s1;
            // DMA cycles are device-to-host, so they reuse the read strobe/capture path
            if (grant_dma) begin
                is_dma  <= 1'b1;
                is_read <= 1'b1;
                ch_q    <= grant_ch;
                addr_q  <= '0;
            end else if (grant_host) begin
                is_dma  <= 1'b0;
                is_read <= avs_read;
                ch_q    <= '0;
                addr_q  <= avs_address;
                wdata_q <= avs_writedata;
            end
            if (state == CMD && cnt == CMD_LAST && is_read)
                cap_q <= isa_data_in;
            if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                isa_clk_q <= ~isa_clk_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign busy            = (state == SETUP) || (state == CMD) || (state == HOLD) || (state == DONE);
    assign isa_address     = (busy && !is_dma) ? addr_q : '0;
    assign isa_aen         = busy && is_dma;
    assign isa_dack_n      = (busy && is_dma) ? ~(NUM_DMA'(1) << ch_q) : '1;
    assign isa_ior_n       = !(state == CMD && is_read);
    assign isa_iow_n       = !(state == CMD && !is_read);
    assign isa_data_oe     = !is_read && ((state == SETUP) || (state == CMD) || (state == HOLD));
    assign isa_data_out    = wdata_q;
    assign avs_waitrequest = !(state == DONE && !is_dma);
    assign avs_readdata    = cap_q;
    assign dma_valid       = (state == DONE) && is_dma;
    assign dma_data        = cap_q;
    assign dma_channel     = ch_q;
    assign irq_out         = irq_s2;
    assign isa_clk         = isa_clk_q;
    assign isa_reset       = (state == RSTHOLD);
    assign state_out       = state;

endmodule

// File: tb/tb_isa_bus_engine.sv
// Self-checking bench for isa_bus_engine: directed scenarios plus randomized
// host/DMA traffic checked against a transaction-level expectation model.
module tb_isa_bus_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] avs_address, avs_writedata, avs_readdata;
    logic        avs_read, avs_write, avs_waitrequest;
    logic [15:0] isa_address, isa_data_out, isa_data_in;
    logic        isa_aen, isa_data_oe, isa_ior_n, isa_iow_n, isa_clk, isa_reset;
    logic [3:0]  isa_drq, isa_dack_n, isa_irq, irq_out;
    logic        dma_valid, dma_ready;
    logic [15:0] dma_data;
    logic [2:0]  dma_channel;
    logic [3:0]  state_out;

    int n_cmp = 0;
    int n_err = 0;

    isa_bus_engine dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .isa_address(isa_address), .isa_aen(isa_aen), .isa_data_out(isa_data_out),
        .isa_data_in(isa_data_in), .isa_data_oe(isa_data_oe),
        .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
        .isa_clk(isa_clk), .isa_reset(isa_reset),
        .isa_drq(isa_drq), .isa_dack_n(isa_dack_n),
        .isa_irq(isa_irq), .irq_out(irq_out),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_data(dma_data),
        .dma_channel(dma_channel), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts isa_reset-high clocks from the current cycle onward
    task automatic count_rsthold(input string tag);
        int n = 0;
        while (isa_reset && n < 100) begin
            n++;
            tick;
        end
        chk(tag, n, 16);
        chk({tag, "_idle"}, state_out, 0);
    endtask

    // One host cycle issued from IDLE; read wins when both strobes requested
    task automatic host_cycle(input bit rd, input bit wr, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [15:0] din);
        int t = 0, ior_cnt = 0, iow_cnt = 0, oe_cnt = 0, first_ior = 0;
        int bad_addr = 0, bad_wd = 0;
        bit done = 0, exp_rd;
        logic [15:0] rdata = '0;
        exp_rd = rd;
        isa_data_in = din; avs_address = addr; avs_writedata = wd;
        avs_read = rd; avs_write = wr;
        while (!done && t < 100) begin
            tick;
            t++;
            if (!isa_ior_n) begin
                ior_cnt++;
                if (first_ior == 0) first_ior = t;
            end
            if (!isa_iow_n) iow_cnt++;
            if (isa_data_oe) begin
                oe_cnt++;
                if (isa_data_out !== wd) bad_wd++;
            end
            if (state_out != 0 && isa_address !== addr) bad_addr++;
            if (!avs_waitrequest) begin
                done = 1;
                rdata = avs_readdata;
            end
        end
        avs_read = 0; avs_write = 0;
        chk("host_wait_lat", t, 8);
        chk("host_ior_cnt", ior_cnt, exp_rd ? 4 : 0);
        chk("host_iow_cnt", iow_cnt, exp_rd ? 0 : 4);
        chk("host_oe_cnt", oe_cnt, exp_rd ? 0 : 7);
        chk("host_addr", bad_addr, 0);
        chk("host_wdata", bad_wd, 0);
        if (exp_rd) begin
            chk("host_ior_first", first_ior, 3);
            chk("host_rdata", rdata, {16'h0, din});
        end
        tick;
        chk("host_post", {avs_waitrequest, state_out}, {1'b1, 4'd0});
    endtask

    // DMA burst for every channel in mask, optionally with a host read queued behind it
    task automatic dma_run(input logic [3:0] mask, input bit with_host,
                           input logic [15:0] addr, input logic [15:0] din, input int max_stall);
        int q[$];
        int t = 0, stall;
        bit host_done;
        logic [3:0] dexp;
        for (int i = 0; i < 4; i++) if (mask[i]) q.push_back(i);
        host_done = !with_host;
        isa_data_in = din; isa_drq = mask; avs_write = 0; avs_address = addr;
        tick; tick;
        avs_read = with_host;
        stall = $urandom_range(max_stall);
        while ((q.size() > 0 || !host_done) && t < 500) begin
            for (int i = 0; i < 4; i++) if (!isa_dack_n[i]) isa_drq[i] = 1'b0;
            if (dma_valid) begin
                if (stall > 0) begin
                    stall--;
                end else begin
                    dexp = (q.size() > 0) ? ~(4'b0001 << q[0]) : 4'hF;
                    chk("dma_ch", dma_channel, (q.size() > 0) ? q[0] : 7);
                    chk("dma_dack", isa_dack_n, dexp);
                    chk("dma_data", dma_data, din);
                    chk("dma_aen", isa_aen, 1);
                    chk("dma_addr", isa_address, 0);
                    if (q.size() > 0) void'(q.pop_front());
                    dma_ready = 1;
                    stall = $urandom_range(max_stall);
                end
            end
            if (!avs_waitrequest && avs_read) begin
                chk("host_after_dma", q.size(), 0);
                chk("host_rd_after_dma", avs_readdata, din);
                host_done = 1;
                avs_read = 0;
            end
            tick;
            t++;
            dma_ready = 0;
        end
        chk("dma_timeout", t < 500, 1);
        chk("dma_idle", state_out, 0);
    endtask

    initial begin
        int n;
        logic [3:0] v;
        reset = 1; avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
        isa_data_in = 0; isa_drq = 0; isa_irq = 0; dma_ready = 0;
        tick; tick; tick;
        chk("rst_state", state_out, 1);
        chk("rst_isa_reset", isa_reset, 1);
        chk("rst_strobes", {isa_ior_n, isa_iow_n, isa_aen, isa_data_oe, dma_valid}, 5'b11000);
        chk("rst_wait", avs_waitrequest, 1);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_dack", isa_dack_n, 4'hF);
        chk("rst_isa_clk", isa_clk, 0);
        chk("rst_addr", isa_address, 0);
        reset = 0;
        count_rsthold("rsthold_len");

        // isa_clk period
        n = 0;
        while (!isa_clk && n < 50) begin tick; n++; end
        n = 0;
        while (isa_clk && n < 50) begin tick; n++; end
        chk("isa_clk_high", n, 4);
        while (!isa_clk && n < 50) begin tick; n++; end
        chk("isa_clk_period", n, 8);

        host_cycle(1, 0, 16'h0220, 16'h0000, 16'h00A5);
        host_cycle(0, 1, 16'h0388, 16'h1234, 16'h5A5A);
        host_cycle(1, 1, 16'h0300, 16'hBEEF, 16'hC3C3);
        dma_run(4'b1010, 1, 16'h0220, 16'h7E81, 0);

        // DONE held while consumer stalls
        isa_drq = 4'b0100; isa_data_in = 16'h3C3C;
        n = 0;
        while (!dma_valid && n < 100) begin
            if (!isa_dack_n[2]) isa_drq[2] = 1'b0;
            tick; n++;
        end
        chk("stall_reach_done", dma_valid, 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (state_out == 5 && dma_valid && isa_dack_n == 4'b1011) n++;
            tick;
        end
        chk("stall_hold", n, 10);
        dma_ready = 1;
        tick;
        dma_ready = 0;
        chk("stall_release", state_out, 0);

        // IRQ pulse and steady patterns
        isa_irq = 4'b0100;
        tick;
        isa_irq = 4'b0000;
        chk("irq_lat1", irq_out, 0);
        tick;
        chk("irq_lat2", irq_out, 4'b0100);
        tick;
        chk("irq_clear", irq_out, 0);
        for (int i = 0; i < 4; i++) begin
            v = 4'($urandom);
            isa_irq = v;
            tick; tick;
            chk("irq_rand", irq_out, v);
        end
        isa_irq = 0;

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1) == 1) begin
                n = $urandom_range(2);
                host_cycle(n != 1, n != 0, 16'($urandom), 16'($urandom), 16'($urandom));
            end else begin
                dma_run(4'($urandom_range(15, 1)), 1'($urandom), 16'($urandom),
                        16'($urandom), 3);
            end
        end

        // Reset in the middle of a read strobe
        avs_address = 16'h0220; avs_read = 1; isa_data_in = 16'h1111;
        n = 0;
        while (isa_ior_n && n < 50) begin tick; n++; end
        chk("midrst_in_cmd", {isa_ior_n, state_out}, {1'b0, 4'd3});
        reset = 1;
        tick;
        avs_read = 0;
        chk("midrst_ior", isa_ior_n, 1);
        chk("midrst_state", state_out, 1);
        chk("midrst_rdata", avs_readdata, 0);
        chk("midrst_isa_clk", isa_clk, 0);
        chk("midrst_wait", avs_waitrequest, 1);
        reset = 0;
        count_rsthold("midrst_rsthold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
